// File: rtl/sa_matmul_sched_if.sv
// Bus bundle for the systolic-array matmul scheduler: start request in,
// memory strobes/addresses, array mode, status and debug state out.
interface sa_matmul_sched_if #(
    parameter int M_W = 8
);
    // i_start is a level request: it is sampled only while the scheduler is
    // IDLE, and is taken (with i_m_len) on the first such rising edge; there
    // is no ready back-pressure, o_busy low means the next start is accepted.
    logic           i_start;
    logic [M_W-1:0] i_m_len;
    logic           o_w_rd_en;
    logic [M_W-1:0] o_w_addr;
    logic           o_in_rd_en;
    logic [M_W-1:0] o_in_addr;
    logic           o_sa_preload;
    logic           o_in_valid;
    logic           o_out_wr_en;
    logic [M_W-1:0] o_out_addr;
    logic           o_busy;
    logic           o_done;
    logic [31:0]    o_cycles;
    logic [2:0]     o_dbg_state;

    modport master (
        output i_start, i_m_len,
        input  o_w_rd_en, o_w_addr, o_in_rd_en, o_in_addr, o_sa_preload,
               o_in_valid, o_out_wr_en, o_out_addr, o_busy, o_done,
               o_cycles, o_dbg_state
    );

    modport slave (
        input  i_start, i_m_len,
        output o_w_rd_en, o_w_addr, o_in_rd_en, o_in_addr, o_sa_preload,
               o_in_valid, o_out_wr_en, o_out_addr, o_busy, o_done,
               o_cycles, o_dbg_state
    );
endinterface

// File: rtl/sa_matmul_sched.sv
// Weight-stationary systolic matmul scheduler: preload weights, stream inputs,
// drain outputs. Optional performance counter enabled by SA_SCHED_PERF_EN.
module sa_matmul_sched #(
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 3,
    parameter int M_W      = 8
) (
    input  logic            clk,
    input  logic            rst,
    sa_matmul_sched_if.slave bus
);
    localparam int L    = NUM_ROWS + NUM_COLS;
    localparam int SR_W = L - 1;
    localparam logic [M_W-1:0] LAST_W = M_W'(NUM_ROWS - 1);
    localparam logic [M_W-1:0] ONE    = M_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [M_W-1:0]  m_len_q, m_len_d;
    logic            w_rd_en_q, w_rd_en_d;
    logic [M_W-1:0]  w_addr_q, w_addr_d;
    logic            in_rd_en_q, in_rd_en_d;
    logic [M_W-1:0]  in_addr_q, in_addr_d;
    logic            sa_preload_q, sa_preload_d;
    logic [SR_W-1:0] sr_q, sr_d;
    logic            out_wr_en_q, out_wr_en_d;
    logic [M_W-1:0]  out_addr_q, out_addr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        m_len_d = m_len_q;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = LOAD_W;
                    m_len_d = bus.i_m_len;
                end
            end
            LOAD_W: begin
                if (w_addr_q == LAST_W) begin
                    state_d = (m_len_q == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (in_addr_q == m_len_q - ONE) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_wr_en_q && (out_addr_q == m_len_q - ONE)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes and addresses are computed from the next state so every
        // output lines up with the state it belongs to while still coming
        // straight from a flop. Counters restart at 0 on each state entry.
        w_rd_en_d  = (state_d == LOAD_W);
        w_addr_d   = (w_rd_en_d && w_rd_en_q) ? (w_addr_q + ONE) : '0;
        in_rd_en_d = (state_d == STREAM);
        in_addr_d  = (in_rd_en_d && in_rd_en_q) ? (in_addr_q + ONE) : '0;

        // Memory data arrives one cycle after the read strobe.
        sa_preload_d = w_rd_en_q;

        // sr_q[k] holds the input read strobe from k+1 cycles ago; the write
        // strobe therefore trails the read strobe by exactly L cycles.
        sr_d        = SR_W'({sr_q, in_rd_en_q});
        out_wr_en_d = sr_q[SR_W-1];
        out_addr_d  = (out_wr_en_d && out_wr_en_q) ? (out_addr_q + ONE) : '0;

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            m_len_q      <= '0;
            w_rd_en_q    <= 1'b0;
            w_addr_q     <= '0;
            in_rd_en_q   <= 1'b0;
            in_addr_q    <= '0;
            sa_preload_q <= 1'b0;
            sr_q         <= '0;
            out_wr_en_q  <= 1'b0;
            out_addr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            m_len_q      <= m_len_d;
            w_rd_en_q    <= w_rd_en_d;
            w_addr_q     <= w_addr_d;
            in_rd_en_q   <= in_rd_en_d;
            in_addr_q    <= in_addr_d;
            sa_preload_q <= sa_preload_d;
            sr_q         <= sr_d;
            out_wr_en_q  <= out_wr_en_d;
            out_addr_q   <= out_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef SA_SCHED_PERF_EN
    logic [31:0] cycles_q, cycles_d;
    logic        start_acc;

    // Counts busy cycles including the DONE cycle, so the value seen with
    // o_done equals the start-to-done latency; it then holds until restart.
    always_comb begin
        start_acc = (state_q == IDLE) && bus.i_start;
        cycles_d  = cycles_q;
        if (start_acc) begin
            cycles_d = 32'd1;
        end else if (state_d != IDLE) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign bus.o_cycles = cycles_q;
`else
    assign bus.o_cycles = '0;
`endif

    assign bus.o_w_rd_en    = w_rd_en_q;
    assign bus.o_w_addr     = w_addr_q;
    assign bus.o_in_rd_en   = in_rd_en_q;
    assign bus.o_in_addr    = in_addr_q;
    assign bus.o_sa_preload = sa_preload_q;
    assign bus.o_in_valid   = sr_q[0];
    assign bus.o_out_wr_en  = out_wr_en_q;
    assign bus.o_out_addr   = out_addr_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_dbg_state  = state_q;
endmodule

// File: tb/tb_sa_matmul_sched.sv
// Bench for sa_matmul_sched: table of m_len runs plus hand-written sequences
// for held start and mid-stream reset, with a per-strobe expected queue.
module tb_sa_matmul_sched;
    localparam int NR = 3;
    localparam int NC = 3;
    localparam int MW = 8;
    localparam int L  = NR + NC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sa_matmul_sched_if #(.M_W(MW)) bus ();

    sa_matmul_sched #(.NUM_ROWS(NR), .NUM_COLS(NC), .M_W(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Entries are {cycle[23:0], address[7:0]}.
    logic [31:0] exp_w_q[$];
    logic [31:0] exp_in_q[$];
    logic [31:0] exp_out_q[$];
    logic [31:0] exp_done_q[$];

    int m_s0   = -1000;
    int m_len  = 0;
    int m_done = 0;
    int m_perf = 0;
    bit mon_on = 1'b0;

    typedef struct {
        int m_len;
        int done_cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ev(input int c, input int a);
        logic [31:0] r;
        r = {c[23:0], a[7:0]};
        return r;
    endfunction

    function automatic int perf_of(input int done_cyc);
`ifdef SA_SCHED_PERF_EN
        return done_cyc;
`else
        return 0;
`endif
    endfunction

    // Monitor: sample outputs on the falling edge, match strobes to the queues.
    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.o_w_rd_en) begin
                if (exp_w_q.size() == 0) chk("w_rd_unexpected", 1, 0);
                else chk("w_rd", ev(cyc, int'(bus.o_w_addr)), exp_w_q.pop_front());
            end
            if (bus.o_in_rd_en) begin
                if (exp_in_q.size() == 0) chk("in_rd_unexpected", 1, 0);
                else chk("in_rd", ev(cyc, int'(bus.o_in_addr)), exp_in_q.pop_front());
            end
            if (bus.o_out_wr_en) begin
                if (exp_out_q.size() == 0) chk("out_wr_unexpected", 1, 0);
                else chk("out_wr", ev(cyc, int'(bus.o_out_addr)), exp_out_q.pop_front());
            end
            if (bus.o_done) begin
                if (exp_done_q.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    chk("done", ev(cyc, 0), exp_done_q.pop_front());
                    chk("perf", bus.o_cycles, m_perf);
                end
            end
            chk("busy", bus.o_busy, (cyc >= m_s0 + 1) && (cyc <= m_s0 + m_done));
            chk("preload", bus.o_sa_preload, (cyc >= m_s0 + 2) && (cyc <= m_s0 + NR + 1));
            chk("in_valid", bus.o_in_valid,
                (cyc >= m_s0 + NR + 2) && (cyc <= m_s0 + NR + 1 + m_len));
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_w_rd_en"},    bus.o_w_rd_en, 0);
        chk({tag, "_w_addr"},     bus.o_w_addr, 0);
        chk({tag, "_in_rd_en"},   bus.o_in_rd_en, 0);
        chk({tag, "_in_addr"},    bus.o_in_addr, 0);
        chk({tag, "_sa_preload"}, bus.o_sa_preload, 0);
        chk({tag, "_in_valid"},   bus.o_in_valid, 0);
        chk({tag, "_out_wr_en"},  bus.o_out_wr_en, 0);
        chk({tag, "_out_addr"},   bus.o_out_addr, 0);
        chk({tag, "_busy"},       bus.o_busy, 0);
        chk({tag, "_done"},       bus.o_done, 0);
        chk({tag, "_cycles"},     bus.o_cycles, 0);
        chk({tag, "_state"},      bus.o_dbg_state, 0);
    endtask

    // Called at a falling edge; the following rising edge accepts the start.
    task automatic start_op(input int m, input int done_cyc, input bit hold);
        bus.i_start = 1'b1;
        bus.i_m_len = MW'(m);
        m_s0   = cyc;
        m_len  = m;
        m_done = done_cyc;
        m_perf = perf_of(done_cyc);
        for (int i = 0; i < NR; i++) exp_w_q.push_back(ev(m_s0 + 1 + i, i));
        for (int i = 0; i < m; i++) begin
            exp_in_q.push_back(ev(m_s0 + NR + 1 + i, i));
            exp_out_q.push_back(ev(m_s0 + NR + 1 + L + i, i));
        end
        exp_done_q.push_back(ev(m_s0 + done_cyc, 0));
        @(posedge clk);
        #1;
        if (!hold) bus.i_start = 1'b0;
        bus.i_m_len = MW'($urandom_range(0, 255));
    endtask

    task automatic wait_op();
        while (cyc < m_s0 + m_done + 2) @(negedge clk);
        chk("w_left",    exp_w_q.size(), 0);
        chk("in_left",   exp_in_q.size(), 0);
        chk("out_left",  exp_out_q.size(), 0);
        chk("done_left", exp_done_q.size(), 0);
    endtask

    task automatic flush_model();
        exp_w_q.delete();
        exp_in_q.delete();
        exp_out_q.delete();
        exp_done_q.delete();
        m_s0 = -1000;
    endtask

    initial begin
        vecs[0] = '{3, 13};
        vecs[1] = '{10, 20};
        vecs[2] = '{0, 4};
        vecs[3] = '{1, 11};
        vecs[4] = '{6, 16};
        vecs[5] = '{7, 17};
        vecs[6] = '{2, 12};

        bus.i_start = 1'b0;
        bus.i_m_len = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset");

        @(negedge clk);
        rst    = 1'b0;
        mon_on = 1'b1;

        // Table runs; the first one starts on the first edge after reset.
        for (int v = 0; v < 7; v++) begin
            start_op(vecs[v].m_len, vecs[v].done_cyc, 1'b0);
            wait_op();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Random lengths against the closed-form latency.
        for (int r = 0; r < 4; r++) begin
            int m;
            m = $urandom_range(0, 20);
            start_op(m, (m == 0) ? NR + 1 : 2 * NR + NC + m + 1, 1'b0);
            wait_op();
            @(negedge clk);
        end

        // Start held high: one op, then the next begins on the first IDLE cycle.
        start_op(3, 13, 1'b1);
        while (cyc < m_s0 + 14) @(negedge clk);
        start_op(5, 15, 1'b0);
        wait_op();
        @(negedge clk);

        // Reset during STREAM cycle 5 aborts the op silently.
        start_op(3, 13, 1'b0);
        while (cyc < m_s0 + 5) @(negedge clk);
        #2;
        rst = 1'b1;
        flush_model();
        #1;
        chk_zero("abort");
        @(negedge clk);
        chk_zero("abort_hold");
        rst = 1'b0;
        start_op(3, 13, 1'b0);
        wait_op();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sa_matmul_sched.md
SA_MATMUL_SCHED -- requirements
Module: sa_matmul_sched

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 3, systolic height K (weight rows to preload).
REQ-002 SHALL have parameter NUM_COLS, default 3, systolic width N.
REQ-003 SHALL have parameter M_W, default 8, width of streaming-length field and memory addresses.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_start  input  1  start request, sampled only in IDLE.
REQ-007 SHALL have port i_m_len  input  M_W  streaming dimension M, captured when start is accepted.
REQ-008 SHALL have port o_w_rd_en / o_w_addr  output  1 / M_W  weight memory read strobe and row address.
REQ-009 SHALL have port o_in_rd_en / o_in_addr  output  1 / M_W  input memory read strobe and row address.
REQ-010 SHALL have port o_sa_preload  output  1  array mode: 1 = shift weights in, 0 = compute.
REQ-011 SHALL have port o_in_valid  output  1  input data on array edge is valid (o_in_rd_en delayed one cycle).
REQ-012 SHALL have port o_out_wr_en / o_out_addr  output  1 / M_W  output memory write strobe and row address.
REQ-013 SHALL have port o_busy, o_done  output  1 each  busy level; one-cycle completion pulse.
REQ-014 SHALL have port o_cycles  output  32  performance counter (see Configuration).

Function
REQ-015 SHALL implement FSM IDLE -> LOAD_W -> STREAM -> DRAIN -> DONE -> IDLE.
REQ-016 IDLE: start accepted on rising edge with i_start=1; i_m_len latched as m_len; next state LOAD_W.
REQ-017 LOAD_W: exactly NUM_ROWS cycles, o_w_rd_en=1, o_w_addr=0..NUM_ROWS-1; then STREAM.
REQ-018 o_sa_preload SHALL equal o_w_rd_en delayed one cycle (1-cycle memory read latency).
REQ-019 STREAM: exactly m_len cycles, o_in_rd_en=1, o_in_addr=0..m_len-1; then DRAIN.
REQ-020 Output writes SHALL begin L=NUM_ROWS+NUM_COLS cycles after first STREAM cycle, run m_len consecutive cycles, o_out_addr=0..m_len-1.
REQ-021 DRAIN SHALL persist until the last output write has issued; write issue may overlap STREAM when m_len>L.
REQ-022 DONE: one cycle, o_done=1; then IDLE.
REQ-023 Start-to-done latency (acceptance edge to o_done high) SHALL be 2*NUM_ROWS+NUM_COLS+m_len+1 cycles.
REQ-024 o_busy SHALL be 1 in every state except IDLE.
REQ-025 i_start outside IDLE SHALL be ignored; i_m_len changes after acceptance SHALL have no effect.
REQ-026 m_len=0: LOAD_W still executes; STREAM/DRAIN skipped, no input reads or output writes; DONE follows LOAD_W.
REQ-027 All address counters SHALL be M_W wide, reset to 0 on each state entry, never wrap within an operation.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst=1 SHALL immediately force IDLE and drive every output to 0 (all strobes, addresses, o_sa_preload, o_in_valid, o_busy, o_done, o_cycles).
REQ-030 Reset mid-operation SHALL abort with no o_done pulse; no memory strobes after rst asserts.
REQ-031 First start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-032 Macro SA_SCHED_PERF_EN SHALL gate the performance counter.
REQ-033 With SA_SCHED_PERF_EN: o_cycles cleared at start acceptance, +1 per busy cycle, held from o_done until next start.
REQ-034 Without SA_SCHED_PERF_EN: o_cycles tied to 0, no counter logic synthesized; all other behaviour identical.

Verification
REQ-035 NUM_ROWS=NUM_COLS=3, m_len=3, start at cycle 0 -> w reads cycles 1-3, in reads 4-6, out writes 10-12 addr 0-2, o_done at cycle 13.
REQ-036 Same config, m_len=10 -> in reads cycles 4-13, writes 10-19 overlap STREAM, o_done cycle 20; PERF_EN: o_cycles=20.
REQ-037 m_len=0 -> w reads cycles 1-3, zero in/out strobes, o_done cycle 4.
REQ-038 i_start held high throughout run -> single operation, back-to-back second op accepted first IDLE cycle after o_done.
REQ-039 rst pulsed during STREAM cycle 5 -> all outputs 0 same cycle, no o_done, next start runs full REQ-035 timeline.
REQ-040 Build without SA_SCHED_PERF_EN -> o_cycles=0 always, REQ-035 timeline unchanged.
